tag_resolver: RTL and testbench

Multiple-response resolver on the read side of the associative-processor cell array: takes a snapshot of the per-row tag vector produced by a compare pass and emits the index of every matching row, lowest first, one per handshake. Sits between the cell array's tag outputs (combined across columns) and the AP controller/output path. It also reports the match count and any-match status.

---
 rtl/tag_resolver.sv | 92 +++++++++
 tb/tb_tag_resolver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tag_resolver.sv
// Walks a captured row-tag vector and hands out matching row indices lowest-first, one per
// idx_valid/idx_ready transfer; outputs decode registered state only, so there is one cycle from start to first index.
module tag_resolver #(
  parameter int DATA_DEPTH = 128,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst_In,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_DEPTH-1:0] tag_in,
  input  logic                  idx_ready,
  output logic                  idx_valid,
  output logic [IDX_W-1:0]      idx_out,
  output logic                  busy,
  output logic                  done,
  output logic                  any_match,
  output logic [IDX_W:0]        match_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_DEPTH-1:0] r_snap;
  logic [IDX_W:0]        r_match_count;
  logic                  r_any_match;

  logic [IDX_W-1:0]      w_idx;
  logic [DATA_DEPTH-1:0] w_snap_clr;
  logic                  w_vld;
  logic                  w_xfer;

  // Scan downward so the last assignment wins with the lowest set bit.
  always_comb begin
    w_idx = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (r_snap[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_snap_clr = r_snap & ~(DATA_DEPTH'(1) << w_idx);
  assign w_vld      = (r_state == S_SCAN) && (r_snap != '0);
  assign w_xfer     = w_vld && idx_ready;

  always_ff @(posedge clk or posedge rst_In) begin
    if (rst_In) begin
      r_state       <= S_IDLE;
      r_snap        <= '0;
      r_match_count <= '0;
      r_any_match   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap        <= tag_in;
            r_any_match   <= |tag_in;
            r_match_count <= '0;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_snap  <= '0;
            r_state <= S_IDLE;
          end else if (r_snap == '0) begin
            r_state <= S_DONE;
          end else if (w_xfer) begin
            r_snap        <= w_snap_clr;
            r_match_count <= r_match_count + (IDX_W+1)'(1);
            if (w_snap_clr == '0) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_snap  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_snap  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign idx_valid   = w_vld;
  assign idx_out     = w_idx;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign any_match   = r_any_match;
  assign match_count = r_match_count;

endmodule

// File: tb/tb_tag_resolver.sv
// Directed-vector bench for tag_resolver with hand-computed expectations.
module tb_tag_resolver;

  logic         clk = 1'b0;
  logic         rst_In;
  logic         start;
  logic         abort;
  logic [127:0] tag_in;
  logic         idx_ready;
  logic         idx_valid;
  logic [6:0]   idx_out;
  logic         busy;
  logic         done;
  logic         any_match;
  logic [7:0]   match_count;

  int n_checks = 0;
  int n_pass   = 0;

  tag_resolver #(.DATA_DEPTH(128), .IDX_W(7)) dut (
    .clk(clk), .rst_In(rst_In), .start(start), .abort(abort), .tag_in(tag_in),
    .idx_ready(idx_ready), .idx_valid(idx_valid), .idx_out(idx_out), .busy(busy),
    .done(done), .any_match(any_match), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_scan(input logic [127:0] t);
    tag_in = t;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_vld"},  32'(idx_valid), 0);
  endtask

  logic [127:0] t;
  logic         rdy_seq [5];
  logic [6:0]   idx_seq [5];

  initial begin
    rst_In = 1'b1; start = 1'b0; abort = 1'b0; tag_in = '0; idx_ready = 1'b0;
    #12;
    chk("rst_vld",   32'(idx_valid), 0);
    chk("rst_idx",   32'(idx_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_any",   32'(any_match), 0);
    chk("rst_cnt",   32'(match_count), 0);
    rst_In = 1'b0;
    tick();

    // Reset mid-scan after two transfers from 0x0F
    idx_ready = 1'b1;
    begin_scan(128'h0F);
    chk("mr_idx0", 32'(idx_out), 0);
    tick();
    tick();
    chk("mr_idx2", 32'(idx_out), 2);
    chk("mr_cnt2", 32'(match_count), 2);
    #2 rst_In = 1'b1;
    #1;
    chk("mr_vld",  32'(idx_valid), 0);
    chk("mr_idx",  32'(idx_out), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_any",  32'(any_match), 0);
    chk("mr_cnt",  32'(match_count), 0);
    rst_In = 1'b0;
    tick();

    // Bits {0,5,127}, ready held high
    t = '0; t[0] = 1'b1; t[5] = 1'b1; t[127] = 1'b1;
    begin_scan(t);
    chk("a_busy", 32'(busy), 1);
    chk("a_vld0", 32'(idx_valid), 1);
    chk("a_idx0", 32'(idx_out), 0);
    tick();
    chk("a_idx1", 32'(idx_out), 5);
    chk("a_cnt1", 32'(match_count), 1);
    tick();
    chk("a_idx2", 32'(idx_out), 127);
    chk("a_vld2", 32'(idx_valid), 1);
    tick();
    chk("a_done", 32'(done), 1);
    chk("a_vld3", 32'(idx_valid), 0);
    chk("a_cnt",  32'(match_count), 3);
    chk("a_any",  32'(any_match), 1);
    tick();
    chk_idle("a_end");

    // Zero matches
    begin_scan('0);
    chk("z_busy1", 32'(busy), 1);
    chk("z_vld1",  32'(idx_valid), 0);
    chk("z_done1", 32'(done), 0);
    tick();
    chk("z_done2", 32'(done), 1);
    chk("z_vld2",  32'(idx_valid), 0);
    tick();
    chk_idle("z_end");
    chk("z_cnt", 32'(match_count), 0);
    chk("z_any", 32'(any_match), 0);

    // Bits {3,64} with ready toggling 0,1,0,0,1
    rdy_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    idx_seq = '{7'd3, 7'd3, 7'd64, 7'd64, 7'd64};
    t = '0; t[3] = 1'b1; t[64] = 1'b1;
    begin_scan(t);
    for (int i = 0; i < 5; i++) begin
      idx_ready = rdy_seq[i];
      chk($sformatf("bp_vld%0d", i), 32'(idx_valid), 1);
      chk($sformatf("bp_idx%0d", i), 32'(idx_out), 32'(idx_seq[i]));
      tick();
    end
    idx_ready = 1'b1;
    chk("bp_done", 32'(done), 1);
    chk("bp_cnt",  32'(match_count), 2);
    tick();
    chk_idle("bp_end");

    // All 128 rows match
    begin_scan({128{1'b1}});
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("all_idx%0d", i), 32'(idx_out), 32'(i));
      tick();
    end
    chk("all_done", 32'(done), 1);
    chk("all_vld",  32'(idx_valid), 0);
    chk("all_cnt",  32'(match_count), 128);
    tick();
    chk_idle("all_end");

    // Bits {1,2,9}: start ignored during scan, then abort after one transfer
    t = '0; t[1] = 1'b1; t[2] = 1'b1; t[9] = 1'b1;
    begin_scan(t);
    chk("ab_idx0", 32'(idx_out), 1);
    tick();
    idx_ready = 1'b0;
    tag_in    = {128{1'b1}};
    start     = 1'b1;
    chk("ab_idx1", 32'(idx_out), 2);
    tick();
    start = 1'b0;
    chk("ab_idx_hold", 32'(idx_out), 2);
    chk("ab_cnt1",     32'(match_count), 1);
    abort     = 1'b1;
    idx_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("ab_post");
    chk("ab_idx", 32'(idx_out), 0);
    chk("ab_cnt", 32'(match_count), 1);
    chk("ab_any", 32'(any_match), 1);
    tick();
    chk("ab_nodone", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
